sel_toggle_bank: RTL

//  Parametrised successor to the single-bit select/toggle flop next-state cone.

---
 rtl/sel_toggle_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/sel_toggle_bank.sv
// rtl/sel_toggle_bank.sv - per-channel select/arm/toggle bank with 2-stage handshake pipeline
//
// Purpose:
//   CHANNELS independent toggle bits. Each channel picks one of 2**SEL_W data
//   bits with its select field, ANDs it with the shared arm, and toggles its
//   state bit when the result is 1. Inputs are taken with a valid/ready
//   handshake into stage 1. Stage 2 applies the toggle and bumps a saturating
//   per-channel counter. A low en synchronously loads state and flushes the pipe.
//
// Optional feature (macro PARITY_OUT_EN):
//   Adds output `parity`, the registered XOR of the state vector, written
//   whenever state is written.
//
// Ports:
//   ck          in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   0 = synchronous load/flush, 1 = run
//   load_val    in   [CHANNELS]            state loaded while en=0
//   arm         in   global qualifier for every selected bit
//   in_valid    in   sel/data/arm valid this cycle
//   in_ready    out  input accepted this cycle
//   sel         in   [CHANNELS*SEL_W]      channel i uses [i*SEL_W +: SEL_W]
//   data        in   [CHANNELS*2**SEL_W]   channel i uses [i*2**SEL_W +: 2**SEL_W]
//   stall       in   downstream backpressure, holds stage 2
//   state       out  [CHANNELS]            toggle state bits
//   toggle_cnt  out  [CHANNELS*CNT_W]      saturating per-channel toggle counts
//   out_valid   out  one-cycle pulse when state/toggle_cnt were updated
//   parity      out  (PARITY_OUT_EN only) XOR of state
module sel_toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                           ck,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [CHANNELS-1:0]            load_val,
  input  logic                           arm,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*SEL_W-1:0]      sel,
  input  logic [CHANNELS*(2**SEL_W)-1:0] data,
  input  logic                           stall,
  output logic [CHANNELS-1:0]            state,
  output logic [CHANNELS*CNT_W-1:0]      toggle_cnt,
  output logic                           out_valid
`ifdef PARITY_OUT_EN
  ,
  output logic                           parity
`endif
);

  localparam int DW = 2**SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                s1_valid;
  logic [CHANNELS-1:0] s1_bits;
  logic [CHANNELS-1:0] new_bits;
  logic                accept;
  logic                consume;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];

  // Ready is forced low during reset; a stalled stage 1 only blocks when full.
  assign in_ready = rst_n & en & (~s1_valid | ~stall);
  assign accept   = in_valid & in_ready;
  assign consume  = s1_valid & ~stall & en;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DW-1:0]    d_slice;
    logic [SEL_W-1:0] s_slice;
    assign d_slice     = data[g*DW +: DW];
    assign s_slice     = sel[g*SEL_W +: SEL_W];
    assign new_bits[g] = arm & d_slice[s_slice];
    assign toggle_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      s1_valid  <= 1'b0;
      s1_bits   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
`ifdef PARITY_OUT_EN
      parity    <= 1'b0;
`endif
    end else if (!en) begin
      // Load/flush wins over everything; any pending or same-cycle token is dropped.
      state     <= load_val;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
`ifdef PARITY_OUT_EN
      parity    <= ^load_val;
`endif
    end else begin
      // Stage 1: a new accept overwrites a token being consumed this same edge.
      if (accept) begin
        s1_bits  <= new_bits;
        s1_valid <= 1'b1;
      end else if (consume) begin
        s1_valid <= 1'b0;
      end

      // Stage 2: apply toggles, counters stick at all-ones.
      out_valid <= consume;
      if (consume) begin
        state <= state ^ s1_bits;
        for (int i = 0; i < CHANNELS; i++) begin
          if (s1_bits[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
`ifdef PARITY_OUT_EN
        parity <= ^(state ^ s1_bits);
`endif
      end
    end
  end

endmodule
